// File: rtl/eth_hdr_pkg.sv
// ============================================================================
// eth_hdr_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the Ethernet header transmit and receive FSMs.
// Both ends import this package so that field lengths, the preamble byte and
// the start-of-frame delimiter agree.
//
// Contents:
//   hdr_state_t          header sequencing states (IDLE..TYPE)
//   PREAMBLE_BYTE_DEF    default preamble byte (8'h55)
//   SFD_BYTE_DEF         default start-of-frame delimiter (8'hD5)
//   DST_LEN/SRC_LEN/TYPE_LEN   header field lengths in bytes
//   addr_byte()          MSB-first byte select from a 48-bit MAC address
//   type_byte()          MSB-first byte select from the 16-bit type/length
// ============================================================================
package eth_hdr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DST,
        ST_SRC,
        ST_TYPE
    } hdr_state_t;

    localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'h55;
    localparam logic [7:0] SFD_BYTE_DEF      = 8'hD5;

    localparam int DST_LEN  = 6;
    localparam int SRC_LEN  = 6;
    localparam int TYPE_LEN = 2;

    // Index of the final byte of each field, sized to the 4-bit byte counter.
    localparam logic [3:0] DST_LAST  = 4'(DST_LEN - 1);
    localparam logic [3:0] SRC_LAST  = 4'(SRC_LEN - 1);
    localparam logic [3:0] TYPE_LAST = 4'(TYPE_LEN - 1);

    // Byte idx of a MAC address, counting from the most significant byte.
    function automatic logic [7:0] addr_byte(input logic [47:0] addr,
                                             input logic [3:0]  idx);
        logic [7:0] result;
        case (idx)
            4'd0:    result = addr[47:40];
            4'd1:    result = addr[39:32];
            4'd2:    result = addr[31:24];
            4'd3:    result = addr[23:16];
            4'd4:    result = addr[15:8];
            4'd5:    result = addr[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // Byte idx of the type/length field, most significant byte first.
    function automatic logic [7:0] type_byte(input logic [15:0] type_len,
                                             input logic [3:0]  idx);
        logic [7:0] result;
        case (idx)
            4'd0:    result = type_len[15:8];
            4'd1:    result = type_len[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/header_tx_fsm.sv
// ============================================================================
// header_tx_fsm
// ----------------------------------------------------------------------------
// Byte-serial Ethernet header generator. A start request latches the
// destination MAC, source MAC and type/length, then the block emits
//   PREAMBLE_LEN x PREAMBLE_BYTE, SFD_BYTE, DST (6 B), SRC (6 B), TYPE (2 B)
// one byte per accepted transfer on a valid/ready stream. Completion strobes
// for each field line up with the field-valid flags of the header receiver.
//
// Parameters:
//   PREAMBLE_LEN   number of preamble bytes before the SFD (legal 1..15)
//   PREAMBLE_BYTE  preamble byte value
//   SFD_BYTE       start-of-frame delimiter value
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-high reset
//   start            frame request, honoured while idle or in the done cycle
//   abort            synchronous cancel of the frame in progress
//   dst_addr         destination MAC, [47:40] sent first
//   src_addr         source MAC, [47:40] sent first
//   type_length      type/length, [15:8] sent first
//   tx_data          current byte (registered)
//   tx_valid         tx_data is valid (registered)
//   tx_ready         downstream accepts the byte
//   busy             frame in progress
//   done             one-cycle pulse after the last TYPE byte is accepted
//   preamble_sent    one-cycle pulse after the SFD byte is accepted
//   dst_addr_sent    one-cycle pulse after the last DST byte is accepted
//   src_addr_sent    one-cycle pulse after the last SRC byte is accepted
//   type_length_sent one-cycle pulse after the last TYPE byte is accepted
// ============================================================================
module header_tx_fsm
    import eth_hdr_pkg::*;
#(
    parameter int         PREAMBLE_LEN  = 7,
    parameter logic [7:0] PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
    parameter logic [7:0] SFD_BYTE      = SFD_BYTE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        preamble_sent,
    output logic        dst_addr_sent,
    output logic        src_addr_sent,
    output logic        type_length_sent
);

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

    hdr_state_t  state, state_d;
    logic [3:0]  byte_cnt, byte_cnt_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  tx_data_d;
    logic        tx_valid_d;
    logic        busy_d;
    logic        done_d;
    logic        preamble_sent_d;
    logic        dst_addr_sent_d;
    logic        src_addr_sent_d;
    logic        type_length_sent_d;
    logic        transfer;
    logic        launch;

    assign transfer = tx_valid & tx_ready;

    // State register. Every output is registered here, so all of them drop to
    // zero the moment reset is asserted, even with the clock stopped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            byte_cnt         <= 4'd0;
            dst_q            <= 48'd0;
            src_q            <= 48'd0;
            type_q           <= 16'd0;
            tx_data          <= 8'h00;
            tx_valid         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            preamble_sent    <= 1'b0;
            dst_addr_sent    <= 1'b0;
            src_addr_sent    <= 1'b0;
            type_length_sent <= 1'b0;
        end else begin
            state            <= state_d;
            byte_cnt         <= byte_cnt_d;
            dst_q            <= dst_d;
            src_q            <= src_d;
            type_q           <= type_d;
            tx_data          <= tx_data_d;
            tx_valid         <= tx_valid_d;
            busy             <= busy_d;
            done             <= done_d;
            preamble_sent    <= preamble_sent_d;
            dst_addr_sent    <= dst_addr_sent_d;
            src_addr_sent    <= src_addr_sent_d;
            type_length_sent <= type_length_sent_d;
        end
    end

    // Next-state logic. Strobes and done default to 0 so they can only ever
    // be high for the single cycle following the transfer that raised them.
    // A stall simply leaves every held register at its current value.
    always_comb begin
        state_d            = state;
        byte_cnt_d         = byte_cnt;
        dst_d              = dst_q;
        src_d              = src_q;
        type_d             = type_q;
        tx_valid_d         = tx_valid;
        busy_d             = busy;
        done_d             = 1'b0;
        preamble_sent_d    = 1'b0;
        dst_addr_sent_d    = 1'b0;
        src_addr_sent_d    = 1'b0;
        type_length_sent_d = 1'b0;
        launch             = 1'b0;

        if (state != ST_IDLE && abort) begin
            // Abort wins over a transfer at the same edge and suppresses any
            // strobe that transfer would have produced.
            state_d    = ST_IDLE;
            byte_cnt_d = 4'd0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    launch = start;
                end

                ST_PREAMBLE: begin
                    if (transfer) begin
                        if (byte_cnt == PRE_LAST) begin
                            state_d    = ST_SFD;
                            byte_cnt_d = 4'd0;
                        end else begin
                            byte_cnt_d = byte_cnt + 4'd1;
                        end
                    end
                end

                ST_SFD: begin
                    if (transfer) begin
                        state_d         = ST_DST;
                        byte_cnt_d      = 4'd0;
                        preamble_sent_d = 1'b1;
                    end
                end

                ST_DST: begin
                    if (transfer) begin
                        if (byte_cnt == DST_LAST) begin
                            state_d         = ST_SRC;
                            byte_cnt_d      = 4'd0;
                            dst_addr_sent_d = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt + 4'd1;
                        end
                    end
                end

                ST_SRC: begin
                    if (transfer) begin
                        if (byte_cnt == SRC_LAST) begin
                            state_d         = ST_TYPE;
                            byte_cnt_d      = 4'd0;
                            src_addr_sent_d = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt + 4'd1;
                        end
                    end
                end

                ST_TYPE: begin
                    if (transfer) begin
                        if (byte_cnt == TYPE_LAST) begin
                            // The done cycle also accepts a new start, so a
                            // held start yields back-to-back frames with no
                            // idle gap.
                            state_d            = ST_IDLE;
                            byte_cnt_d         = 4'd0;
                            tx_valid_d         = 1'b0;
                            busy_d             = 1'b0;
                            done_d             = 1'b1;
                            type_length_sent_d = 1'b1;
                            launch             = start;
                        end else begin
                            byte_cnt_d = byte_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 4'd0;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end
            endcase
        end

        if (launch) begin
            state_d    = ST_PREAMBLE;
            byte_cnt_d = 4'd0;
            dst_d      = dst_addr;
            src_d      = src_addr;
            type_d     = type_length;
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
        end
    end

    // Byte select on {state, byte_cnt} of the upcoming cycle. While stalled
    // the state and counter hold, so the selected byte holds with them.
    always_comb begin
        tx_data_d = 8'h00;
        case (state_d)
            ST_PREAMBLE: tx_data_d = PREAMBLE_BYTE;
            ST_SFD:      tx_data_d = SFD_BYTE;
            ST_DST:      tx_data_d = addr_byte(dst_d, byte_cnt_d);
            ST_SRC:      tx_data_d = addr_byte(src_d, byte_cnt_d);
            ST_TYPE:     tx_data_d = type_byte(type_d, byte_cnt_d);
            default:     tx_data_d = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_header_tx_fsm.sv
// ============================================================================
// tb_header_tx_fsm
// ----------------------------------------------------------------------------
// Bench for header_tx_fsm. Two instances share all inputs: u0 uses the default
// seven-byte preamble and u1 a single preamble byte. A frame-position model
// (byte index within the frame, busy flag, latched fields) predicts every
// output of both instances each cycle; directed frames compare captured bytes
// and strobe timing against literal tables.
// ============================================================================
`timescale 1ns/1ps
module tb_header_tx_fsm;

    logic clock   = 1'b0;
    logic clk_run = 1'b1;
    always #5 if (clk_run) clock = ~clock;

    logic        reset       = 1'b1;
    logic        start       = 1'b0;
    logic        abort       = 1'b0;
    logic        tx_ready    = 1'b1;
    logic [47:0] dst_addr    = 48'd0;
    logic [47:0] src_addr    = 48'd0;
    logic [15:0] type_length = 16'd0;

    logic [7:0] tx_data [2];
    logic [1:0] tx_valid, busy, done, pre_s, dst_s, src_s, typ_s;

    int n_vec = 0;
    int n_err = 0;

    header_tx_fsm #(.PREAMBLE_LEN(7)) u0 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
        .busy(busy[0]), .done(done[0]), .preamble_sent(pre_s[0]),
        .dst_addr_sent(dst_s[0]), .src_addr_sent(src_s[0]),
        .type_length_sent(typ_s[0])
    );

    header_tx_fsm #(.PREAMBLE_LEN(1)) u1 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
        .busy(busy[1]), .done(done[1]), .preamble_sent(pre_s[1]),
        .dst_addr_sent(dst_s[1]), .src_addr_sent(src_s[1]),
        .type_length_sent(typ_s[1])
    );

    // Nominal frame with a seven-byte preamble.
    logic [7:0] nom7 [22] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                              8'hD5,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA,
                              8'h08, 8'h00};

    // ---------------- behavioural model ----------------
    bit          m_busy [2];
    int          m_p    [2];
    bit          m_done [2];
    bit   [3:0]  m_str  [2];
    logic [47:0] m_dst  [2];
    logic [47:0] m_src  [2];
    logic [15:0] m_typ  [2];

    function automatic int plen_of(input int i);
        return (i == 0) ? 7 : 1;
    endfunction

    // Byte at position p of a frame with an L-byte preamble.
    function automatic logic [7:0] frame_byte(input int L, input int p,
                                              input logic [47:0] d,
                                              input logic [47:0] s,
                                              input logic [15:0] t);
        int q;
        logic [47:0] sh;
        logic [15:0] th;
        if (p < L) return 8'h55;
        if (p == L) return 8'hD5;
        q = p - L - 1;
        if (q < 6) begin sh = d << (8 * q); return sh[47:40]; end
        q = q - 6;
        if (q < 6) begin sh = s << (8 * q); return sh[47:40]; end
        q = q - 6;
        th = t << (8 * q);
        return th[15:8];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_p[i] = 0; m_done[i] = 0; m_str[i] = 4'd0;
            m_dst[i] = 48'd0; m_src[i] = 48'd0; m_typ[i] = 16'd0;
        end
    endtask

    task automatic model_launch(input int i);
        m_busy[i] = 1; m_p[i] = 0;
        m_dst[i] = dst_addr; m_src[i] = src_addr; m_typ[i] = type_length;
    endtask

    // Advance one clock edge using the inputs that edge sampled.
    task automatic model_step(input int i);
        int L;
        L = plen_of(i);
        m_done[i] = 0;
        m_str[i]  = 4'd0;
        if (m_busy[i]) begin
            if (abort) begin
                m_busy[i] = 0;
            end else if (tx_ready) begin
                if (m_p[i] == L)      m_str[i][0] = 1'b1;
                if (m_p[i] == L + 6)  m_str[i][1] = 1'b1;
                if (m_p[i] == L + 12) m_str[i][2] = 1'b1;
                if (m_p[i] == L + 14) begin
                    m_str[i][3] = 1'b1;
                    m_done[i]   = 1;
                    m_busy[i]   = 0;
                    if (start) model_launch(i);
                end else begin
                    m_p[i] = m_p[i] + 1;
                end
            end
        end else if (start) begin
            model_launch(i);
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] act,
                                input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic compare_dut(input int i);
        check_output($sformatf("u%0d.tx_valid", i), {7'd0, tx_valid[i]}, {7'd0, m_busy[i]});
        check_output($sformatf("u%0d.busy", i), {7'd0, busy[i]}, {7'd0, m_busy[i]});
        check_output($sformatf("u%0d.done", i), {7'd0, done[i]}, {7'd0, m_done[i]});
        check_output($sformatf("u%0d.strobes", i),
                     {4'd0, typ_s[i], src_s[i], dst_s[i], pre_s[i]}, {4'd0, m_str[i]});
        if (m_busy[i])
            check_output($sformatf("u%0d.tx_data[p=%0d]", i, m_p[i]), tx_data[i],
                         frame_byte(plen_of(i), m_p[i], m_dst[i], m_src[i], m_typ[i]));
    endtask

    // Compare process: outputs are sampled on the falling edge, after the
    // model has absorbed the rising edge that produced them.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                model_clear();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    model_step(i);
                    compare_dut(i);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input logic s, input logic a, input logic r);
        @(negedge clock);
        #1;
        start    = s;
        abort    = a;
        tx_ready = r;
    endtask

    task automatic set_nominal_fields();
        dst_addr    = 48'h010203040506;
        src_addr    = 48'hFFFEFDFCFBFA;
        type_length = 16'h0800;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100; c++) begin
            if (busy == 2'b00) return;
            apply_stimulus(1'b0, 1'b0, 1'b1);
        end
        fail_timeout({tag, ".wait_idle"});
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("%s.u%0d.tx_data", tag, i), tx_data[i], 8'h00);
            check_output($sformatf("%s.u%0d.flags", tag, i),
                         {1'b0, tx_valid[i], busy[i], done[i], pre_s[i], dst_s[i],
                          src_s[i], typ_s[i]}, 8'h00);
        end
    endtask

    // Full frame with tx_ready held high, captured and checked against the
    // literal byte table and strobe positions for both preamble lengths.
    task automatic run_nominal(input string tag);
        logic [7:0] cap_d    [2][23];
        logic [3:0] cap_s    [2][23];
        logic       cap_done [2][23];
        int L;
        set_nominal_fields();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 23; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                cap_d[i][k]    = tx_data[i];
                cap_s[i][k]    = {typ_s[i], src_s[i], dst_s[i], pre_s[i]};
                cap_done[i][k] = done[i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            L = plen_of(i);
            for (int k = 0; k < L + 15; k++)
                check_output($sformatf("%s.u%0d.byte%0d", tag, i, k), cap_d[i][k],
                             (k < L) ? 8'h55 : nom7[k - L + 7]);
            check_output($sformatf("%s.u%0d.preamble_sent", tag, i), {4'd0, cap_s[i][L + 1]}, 8'h01);
            check_output($sformatf("%s.u%0d.dst_addr_sent", tag, i), {4'd0, cap_s[i][L + 7]}, 8'h02);
            check_output($sformatf("%s.u%0d.src_addr_sent", tag, i), {4'd0, cap_s[i][L + 13]}, 8'h04);
            check_output($sformatf("%s.u%0d.type_length_sent", tag, i), {4'd0, cap_s[i][L + 15]}, 8'h08);
            check_output($sformatf("%s.u%0d.done_early", tag, i), {7'd0, cap_done[i][L + 14]}, 8'h00);
            check_output($sformatf("%s.u%0d.done", tag, i), {7'd0, cap_done[i][L + 15]}, 8'h01);
        end
    endtask

    initial begin
        logic [7:0] acc [$];
        bit         seen;
        bit         rdy;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Nominal frame
        run_nominal("nominal");
        wait_idle("nominal");

        // Backpressure: tx_ready pattern 1,0,0,1
        set_nominal_fields();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        seen = 0;
        acc.delete();
        for (int c = 0; c < 200 && !seen; c++) begin
            rdy = (c % 4 == 0) || (c % 4 == 3);
            apply_stimulus(1'b0, 1'b0, rdy);
            if (done[0]) seen = 1;
            else if (tx_valid[0] && rdy) acc.push_back(tx_data[0]);
        end
        if (!seen) fail_timeout("backpressure.done");
        check_output("backpressure.count", 8'(acc.size()), 8'd22);
        for (int k = 0; k < 22 && k < acc.size(); k++)
            check_output($sformatf("backpressure.byte%0d", k), acc[k], nom7[k]);
        wait_idle("backpressure");

        // Back-to-back with start held and inputs changed mid-frame
        set_nominal_fields();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        seen = 0;
        acc.delete();
        for (int c = 0; c < 40 && !seen; c++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1);
            if (done[0]) begin
                seen = 1;
                check_output("b2b.valid_in_done", {7'd0, tx_valid[0]}, 8'h01);
                check_output("b2b.busy_in_done", {7'd0, busy[0]}, 8'h01);
                check_output("b2b.data_in_done", tx_data[0], 8'h55);
            end else begin
                acc.push_back(tx_data[0]);
            end
            dst_addr    = {16'($urandom), $urandom};
            src_addr    = {16'($urandom), $urandom};
            type_length = 16'($urandom);
        end
        if (!seen) fail_timeout("b2b.done");
        for (int k = 0; k < 22 && k < acc.size(); k++)
            check_output($sformatf("b2b.frame1.byte%0d", k), acc[k], nom7[k]);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_idle("b2b");

        // Abort after DST byte 3
        set_nominal_fields();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 11; j++) apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("abort.tx_valid", {7'd0, tx_valid[0]}, 8'h00);
        check_output("abort.busy", {7'd0, busy[0]}, 8'h00);
        check_output("abort.dst_addr_sent", {7'd0, dst_s[0]}, 8'h00);
        check_output("abort.done", {7'd0, done[0]}, 8'h00);
        wait_idle("abort");
        run_nominal("after_abort");
        wait_idle("after_abort");

        // Asynchronous reset during SRC byte 2 with the clock stopped
        set_nominal_fields();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 17; j++) apply_stimulus(1'b0, 1'b0, 1'b1);
        clk_run = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        clk_run = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        run_nominal("after_reset");
        wait_idle("after_reset");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            dst_addr    = {16'($urandom), $urandom};
            src_addr    = {16'($urandom), $urandom};
            type_length = 16'($urandom);
            apply_stimulus($urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                           $urandom_range(0, 9) < 7);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
